// File: rtl/lab3_stim_seq_if.sv
// lab3_stim_seq_if: control, stimulus and truth-table bundle between sequencer and its user
interface lab3_stim_seq_if;
   logic       start;
   logic       abort;
   logic       a;
   logic       b;
   logic       c;
   logic       y_in;
   logic       x_in;
   logic       busy;
   logic       done;
   logic [2:0] vec_idx;
   logic       sample_valid;
   logic [7:0] y_tab;
   logic [7:0] x_tab;
   modport master (
      output start, abort, y_in, x_in,
      input  a, b, c, busy, done, vec_idx, sample_valid, y_tab, x_tab
   );
   modport slave (
      input  start, abort, y_in, x_in,
      output a, b, c, busy, done, vec_idx, sample_valid, y_tab, x_tab
   );
endinterface

// File: rtl/lab3_stim_seq.sv
// lab3_stim_seq: clocked sweep of all 8 abc vectors with y/x truth-table capture
module lab3_stim_seq #(
   parameter int DWELL  = 10,
   parameter int SETTLE = 2
) (
   input logic            clk,
   input logic            rst,
   lab3_stim_seq_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;
   state_t     r_state;
   logic [2:0] r_vec;
   logic [7:0] r_cnt;
   logic       r_busy;
   logic       r_done;
   logic       r_sv;
   logic [7:0] r_y;
   logic [7:0] r_x;
   logic       w_last;
   logic       w_settle;
   assign w_last   = r_cnt == 8'(DWELL - 1);
   assign w_settle = r_cnt == 8'(SETTLE);
   assign {bus.a, bus.b, bus.c} = r_vec;
   assign bus.vec_idx      = r_vec;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.sample_valid = r_sv;
   assign bus.y_tab        = r_y;
   assign bus.x_tab        = r_x;
   // sequencer: sample_valid is set one edge early so it is high exactly while cnt==SETTLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_vec   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sv    <= 1'b0;
         r_y     <= '0;
         r_x     <= '0;
      end else begin
         r_sv <= 1'b0;
         if (r_state == S_DRIVE) begin
            if (bus.abort) begin
               r_state <= S_IDLE;
               r_vec   <= '0;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end else begin
               if (w_settle) begin
                  r_y[r_vec] <= bus.y_in;
                  r_x[r_vec] <= bus.x_in;
               end
               if (w_last) begin
                  r_cnt <= '0;
                  if (r_vec == 3'd7) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_vec <= r_vec + 3'd1;
                     r_sv  <= SETTLE == 0;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
                  r_sv  <= (r_cnt + 8'd1) == 8'(SETTLE);
               end
            end
         end else if (bus.start) begin
            r_state <= S_DRIVE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_sv    <= SETTLE == 0;
            r_y     <= '0;
            r_x     <= '0;
         end
      end
   end
endmodule

// File: tb/tb_lab3_stim_seq.sv
// tb_lab3_stim_seq: scoreboard bench driving a parity/and block model from the sequencer
module tb_lab3_stim_seq;
   localparam int DW = 4;
   localparam int ST = 2;
   typedef struct packed {logic [2:0] v; logic y; logic x;} samp_t;
   logic  clk = 1'b0;
   logic  rst = 1'b1;
   logic  y_zero = 1'b0;
   int    total = 0;
   int    bad = 0;
   samp_t q[$];
   samp_t pend_s;
   logic  pend = 1'b0;
   lab3_stim_seq_if bus();
   lab3_stim_seq #(.DWELL(DW), .SETTLE(ST)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   assign bus.y_in = y_zero ? 1'b0 : (bus.a ^ bus.b ^ bus.c);
   assign bus.x_in = bus.a & bus.b;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, act, exp);
      end
   endtask
   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         samp_t s;
         s.v = 3'(i);
         s.y = y_zero ? 1'b0 : ^s.v;
         s.x = s.v[2] & s.v[1];
         q.push_back(s);
      end
   endtask
   task automatic sweep(input logic [7:0] ey, input logic [7:0] ex);
      for (int k = 0; k < 8 * DW; k++) begin
         chk("busy", 32'(bus.busy), 1);
         chk("done_low", 32'(bus.done), 0);
         chk("vec", 32'(bus.vec_idx), k / DW);
         chk("abc", 32'({bus.a, bus.b, bus.c}), k / DW);
         chk("sv_timing", 32'(bus.sample_valid), 32'((k % DW) == ST));
         if (k == 0) begin
            chk("clr_y", 32'(bus.y_tab), 0);
            chk("clr_x", 32'(bus.x_tab), 0);
         end
         @(negedge clk);
      end
      chk("end_busy", 32'(bus.busy), 0);
      chk("end_done", 32'(bus.done), 1);
      chk("end_abc", 32'({bus.a, bus.b, bus.c}), 7);
      chk("end_sv", 32'(bus.sample_valid), 0);
      chk("y_tab", 32'(bus.y_tab), 32'(ey));
      chk("x_tab", 32'(bus.x_tab), 32'(ex));
   endtask
   always @(negedge clk) begin
      if (pend) begin
         chk("tab_y_bit", 32'(bus.y_tab[pend_s.v]), 32'(pend_s.y));
         chk("tab_x_bit", 32'(bus.x_tab[pend_s.v]), 32'(pend_s.x));
         pend = 1'b0;
      end
      if (bus.sample_valid) begin
         chk("sv_in_drive", 32'(bus.busy), 1);
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sv_unexpected: got pulse at vec %0d want none", bus.vec_idx);
         end else begin
            pend_s = q.pop_front();
            chk("sv_vec", 32'(bus.vec_idx), 32'(pend_s.v));
            pend = 1'b1;
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_abc", 32'({bus.a, bus.b, bus.c}), 0);
      chk("rst_tabs", 32'({bus.y_tab, bus.x_tab}), 0);
      bus.start = 1'b1;
      push(8);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre_rst_vec", 32'(bus.vec_idx), 2);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(bus.busy), 0);
      chk("arst_done", 32'(bus.done), 0);
      chk("arst_vec", 32'(bus.vec_idx), 0);
      chk("arst_abc", 32'({bus.a, bus.b, bus.c}), 0);
      chk("arst_sv", 32'(bus.sample_valid), 0);
      chk("arst_tabs", 32'({bus.y_tab, bus.x_tab}), 0);
      q.delete();
      pend = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_after_rst", 32'({bus.busy, bus.done, bus.vec_idx}), 0);
      bus.start = 1'b1;
      push(8);
      @(negedge clk);
      bus.start = 1'b0;
      sweep(8'h96, 8'hC0);
      bus.start = 1'b1;
      push(8);
      @(negedge clk);
      sweep(8'h96, 8'hC0);
      bus.start = 1'b0;
      @(negedge clk);
      chk("held_no_restart", 32'({bus.busy, bus.done}), 1);
      y_zero = 1'b1;
      bus.start = 1'b1;
      push(8);
      @(negedge clk);
      bus.start = 1'b0;
      sweep(8'h00, 8'hC0);
      y_zero = 1'b0;
      bus.start = 1'b1;
      push(3);
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 40 && bus.vec_idx != 3'd3; i++) @(negedge clk);
      chk("reach_v3", 32'(bus.vec_idx), 3);
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_busy", 32'(bus.busy), 0);
      chk("abort_done", 32'(bus.done), 0);
      chk("abort_abc", 32'({bus.a, bus.b, bus.c}), 0);
      chk("abort_y_tab", 32'(bus.y_tab), 32'h06);
      chk("abort_x_tab", 32'(bus.x_tab), 32'h00);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_idle_noop", 32'({bus.busy, bus.done, bus.y_tab}), 32'h006);
      bus.start = 1'b1;
      push(1);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_both_busy", 32'(bus.busy), 1);
      bus.abort = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      bus.start = 1'b0;
      chk("both_busy", 32'(bus.busy), 0);
      chk("both_done", 32'(bus.done), 0);
      chk("both_vec", 32'(bus.vec_idx), 0);
      repeat (3) @(negedge clk);
      chk("both_no_sweep", 32'({bus.busy, bus.done, bus.vec_idx}), 0);
      chk("sb_empty", 32'(q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
